// File: rtl/control_pkg.sv
// -----------------------------------------------------------------------------
// control_pkg
// Shared definitions for the scalar/vector pipeline control unit:
//   - opcode constants decoded in the Decode stage
//   - alu_op_e   : 3-bit ALU operation (taken straight from funct[2:0] or
//                  from the low opcode bits of immediate instructions)
//   - branch_e   : 2-bit branch type reported in Decode
//   - ctrl_t     : the full set of control bits produced by the decoder
// Optional feature macro: CONTROL_VECTOR_EN (vector instruction support).
// -----------------------------------------------------------------------------
package control_pkg;

  localparam logic [5:0] OP_RTYPE   = 6'b000000;  // scalar R-type
  localparam logic [5:0] OP_VRTYPE  = 6'b000100;  // vector-vector R-type
  localparam logic [5:0] OP_VSRTYPE = 6'b001100;  // vector-scalar R-type
  localparam logic [5:0] OP_LW      = 6'b100000;
  localparam logic [5:0] OP_SW      = 6'b100001;
  localparam logic [5:0] OP_VLW     = 6'b100010;
  localparam logic [5:0] OP_VSW     = 6'b100011;
  localparam logic [5:0] OP_BEQ     = 6'b110010;
  localparam logic [5:0] OP_BNE     = 6'b110001;
  localparam logic [5:0] OP_J       = 6'b111111;

  // Only ADD (000) and SUB (001) are pinned by the datapath contract; the
  // remaining names describe the ALU lanes the encodings select.
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_NOR = 3'b101,
    ALU_MUL = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_EQ   = 2'b01,
    BR_NE   = 2'b10
  } branch_e;

  typedef struct packed {
    logic    regwrite;
    logic    vregwrite;
    logic    memtoreg;
    logic    memwrite;
    logic    memdata;
    logic    memsrc;
    logic    alusrc;
    logic    scalar;
    logic    regdst;
    alu_op_e alucontrol;
    branch_e branch;
    logic    jump;
  } ctrl_t;

  // All-zero control word: what a NOP / bubble looks like.
  function automatic ctrl_t ctrl_nop();
    ctrl_t c;
    c = '0;
    return c;
  endfunction

endpackage

// File: rtl/control_decoder.sv
// -----------------------------------------------------------------------------
// control_decoder
// Purely combinational opcode/funct decoder for the Decode stage.
// Ports:
//   i_op    [5:0]  opcode of the instruction in Decode
//   i_funct [5:0]  funct field (only bits [2:0] select the ALU operation)
//   o_ctrl         full control word (ctrl_t)
// Optional feature macro: CONTROL_VECTOR_EN. When undefined, every vector
// opcode (000100, 001100, 01x1xx, 100010, 100011) decodes as a NOP.
// -----------------------------------------------------------------------------
module control_decoder
  import control_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output ctrl_t      o_ctrl
);

  // funct[5:3] carries no meaning for this control unit.
  logic w_unused_funct;
  assign w_unused_funct = ^i_funct[5:3];

  always_comb begin
    o_ctrl = ctrl_nop();
    casez (i_op)
      OP_RTYPE: begin
        o_ctrl.regwrite   = 1'b1;
        o_ctrl.regdst     = 1'b1;
        o_ctrl.alucontrol = alu_op_e'(i_funct[2:0]);
      end
`ifdef CONTROL_VECTOR_EN
      OP_VRTYPE: begin
        o_ctrl.vregwrite  = 1'b1;
        o_ctrl.regdst     = 1'b1;
        o_ctrl.alucontrol = alu_op_e'(i_funct[2:0]);
      end
      OP_VSRTYPE: begin
        o_ctrl.vregwrite  = 1'b1;
        o_ctrl.regdst     = 1'b1;
        o_ctrl.scalar     = 1'b1;
        o_ctrl.alucontrol = alu_op_e'(i_funct[2:0]);
      end
`endif
      6'b01????: begin
        // Immediate ALU: op[2] picks the destination file, op[3] marks
        // that the scalar operand is broadcast across lanes.
`ifdef CONTROL_VECTOR_EN
        o_ctrl.alusrc     = 1'b1;
        o_ctrl.alucontrol = alu_op_e'({1'b0, i_op[1:0]});
        o_ctrl.regwrite   = ~i_op[2];
        o_ctrl.vregwrite  = i_op[2];
        o_ctrl.scalar     = i_op[3];
`else
        if (!i_op[2]) begin
          o_ctrl.alusrc     = 1'b1;
          o_ctrl.alucontrol = alu_op_e'({1'b0, i_op[1:0]});
          o_ctrl.regwrite   = 1'b1;
          o_ctrl.scalar     = i_op[3];
        end
`endif
      end
      OP_LW: begin
        o_ctrl.regwrite = 1'b1;
        o_ctrl.memtoreg = 1'b1;
        o_ctrl.alusrc   = 1'b1;
      end
      OP_SW: begin
        o_ctrl.memwrite = 1'b1;
        o_ctrl.alusrc   = 1'b1;
      end
`ifdef CONTROL_VECTOR_EN
      OP_VLW: begin
        o_ctrl.vregwrite = 1'b1;
        o_ctrl.memtoreg  = 1'b1;
        o_ctrl.alusrc    = 1'b1;
        o_ctrl.memsrc    = 1'b1;
      end
      OP_VSW: begin
        o_ctrl.memwrite = 1'b1;
        o_ctrl.alusrc   = 1'b1;
        o_ctrl.memsrc   = 1'b1;
        o_ctrl.memdata  = 1'b1;
      end
`endif
      OP_BEQ:  o_ctrl.branch = BR_EQ;
      OP_BNE:  o_ctrl.branch = BR_NE;
      OP_J:    o_ctrl.jump   = 1'b1;
      default: o_ctrl = ctrl_nop();
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
// Pipelined control for the five-stage scalar/vector processor. Decodes in
// Decode, resolves branches in Decode, and carries control bits through the
// E, M and W pipeline registers.
// Ports:
//   clk, reset             clock; asynchronous active-high reset (E/M/W only)
//   opD, functD            instruction fields in Decode
//   srca2D, srcb2D         forwarded compare operands for branch resolution
//   flushE                 loads a bubble into the E register
//   jumpD, branchD, pcsrcD combinational Decode outputs
//   *E, *M, *W             registered control bits for each later stage
// Optional feature macro: CONTROL_VECTOR_EN. When undefined, the vector
// pipeline bits are not built and VregwriteW, scalarE, memdataM, memsrcM
// are tied to 0.
// -----------------------------------------------------------------------------
module control_unit
  import control_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opD,
  input  logic [5:0]  functD,
  input  logic [31:0] srca2D,
  input  logic [31:0] srcb2D,
  input  logic        flushE,
  output logic        jumpD,
  output logic [1:0]  branchD,
  output logic        pcsrcD,
  output logic        alusrcE,
  output logic        scalarE,
  output logic [2:0]  alucontrolE,
  output logic        regdstE,
  output logic        memwriteM,
  output logic        memdataM,
  output logic        memsrcM,
  output logic        regwriteE,
  output logic        regwriteM,
  output logic        regwriteW,
  output logic        VregwriteW,
  output logic        memtoregE,
  output logic        memtoregM,
  output logic        memtoregW
);

  ctrl_t w_ctrl;
  logic  w_equal;

  control_decoder u_decoder (
    .i_op    (opD),
    .i_funct (functD),
    .o_ctrl  (w_ctrl)
  );

  // Decode-stage outputs: combinational, unaffected by reset.
  assign w_equal = (srca2D == srcb2D);
  assign jumpD   = w_ctrl.jump;
  assign branchD = w_ctrl.branch;
  assign pcsrcD  = ((w_ctrl.branch == BR_EQ) &&  w_equal) ||
                   ((w_ctrl.branch == BR_NE) && !w_equal);

  // Scalar pipeline registers
  logic    r_regwrite_e, r_memtoreg_e, r_memwrite_e, r_alusrc_e, r_regdst_e;
  alu_op_e r_alucontrol_e;
  logic    r_regwrite_m, r_memtoreg_m, r_memwrite_m;
  logic    r_regwrite_w, r_memtoreg_w;

`ifdef CONTROL_VECTOR_EN
  // Vector pipeline registers
  logic r_vregwrite_e, r_memdata_e, r_memsrc_e, r_scalar_e;
  logic r_vregwrite_m, r_memdata_m, r_memsrc_m;
  logic r_vregwrite_w;
`else
  // Vector bits from the decoder are constant zero in this build.
  logic w_unused_vec;
  assign w_unused_vec = ^{w_ctrl.vregwrite, w_ctrl.memdata,
                          w_ctrl.memsrc, w_ctrl.scalar};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_regwrite_e   <= 1'b0;
      r_memtoreg_e   <= 1'b0;
      r_memwrite_e   <= 1'b0;
      r_alusrc_e     <= 1'b0;
      r_regdst_e     <= 1'b0;
      r_alucontrol_e <= ALU_ADD;
      r_regwrite_m   <= 1'b0;
      r_memtoreg_m   <= 1'b0;
      r_memwrite_m   <= 1'b0;
      r_regwrite_w   <= 1'b0;
      r_memtoreg_w   <= 1'b0;
`ifdef CONTROL_VECTOR_EN
      r_vregwrite_e  <= 1'b0;
      r_memdata_e    <= 1'b0;
      r_memsrc_e     <= 1'b0;
      r_scalar_e     <= 1'b0;
      r_vregwrite_m  <= 1'b0;
      r_memdata_m    <= 1'b0;
      r_memsrc_m     <= 1'b0;
      r_vregwrite_w  <= 1'b0;
`endif
    end else begin
      // E stage: a flush turns the incoming instruction into a bubble.
      if (flushE) begin
        r_regwrite_e   <= 1'b0;
        r_memtoreg_e   <= 1'b0;
        r_memwrite_e   <= 1'b0;
        r_alusrc_e     <= 1'b0;
        r_regdst_e     <= 1'b0;
        r_alucontrol_e <= ALU_ADD;
`ifdef CONTROL_VECTOR_EN
        r_vregwrite_e  <= 1'b0;
        r_memdata_e    <= 1'b0;
        r_memsrc_e     <= 1'b0;
        r_scalar_e     <= 1'b0;
`endif
      end else begin
        r_regwrite_e   <= w_ctrl.regwrite;
        r_memtoreg_e   <= w_ctrl.memtoreg;
        r_memwrite_e   <= w_ctrl.memwrite;
        r_alusrc_e     <= w_ctrl.alusrc;
        r_regdst_e     <= w_ctrl.regdst;
        r_alucontrol_e <= w_ctrl.alucontrol;
`ifdef CONTROL_VECTOR_EN
        r_vregwrite_e  <= w_ctrl.vregwrite;
        r_memdata_e    <= w_ctrl.memdata;
        r_memsrc_e     <= w_ctrl.memsrc;
        r_scalar_e     <= w_ctrl.scalar;
`endif
      end
      // M and W always advance.
      r_regwrite_m <= r_regwrite_e;
      r_memtoreg_m <= r_memtoreg_e;
      r_memwrite_m <= r_memwrite_e;
      r_regwrite_w <= r_regwrite_m;
      r_memtoreg_w <= r_memtoreg_m;
`ifdef CONTROL_VECTOR_EN
      r_vregwrite_m <= r_vregwrite_e;
      r_memdata_m   <= r_memdata_e;
      r_memsrc_m    <= r_memsrc_e;
      r_vregwrite_w <= r_vregwrite_m;
`endif
    end
  end

  assign regwriteE   = r_regwrite_e;
  assign memtoregE   = r_memtoreg_e;
  assign alusrcE     = r_alusrc_e;
  assign regdstE     = r_regdst_e;
  assign alucontrolE = r_alucontrol_e;
  assign regwriteM   = r_regwrite_m;
  assign memtoregM   = r_memtoreg_m;
  assign memwriteM   = r_memwrite_m;
  assign regwriteW   = r_regwrite_w;
  assign memtoregW   = r_memtoreg_w;

`ifdef CONTROL_VECTOR_EN
  assign scalarE    = r_scalar_e;
  assign memdataM   = r_memdata_m;
  assign memsrcM    = r_memsrc_m;
  assign VregwriteW = r_vregwrite_w;
`else
  assign scalarE    = 1'b0;
  assign memdataM   = 1'b0;
  assign memsrcM    = 1'b0;
  assign VregwriteW = 1'b0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
// Self-checking bench for control_unit. Random and directed instructions are
// compared against an instruction-class reference model; expected E/M/W
// control words travel through an expected queue (index 0 = E, 1 = M, 2 = W).
// Follows the CONTROL_VECTOR_EN setting of the build.
// -----------------------------------------------------------------------------
module tb_control_unit;

`ifdef CONTROL_VECTOR_EN
  localparam bit VEC = 1'b1;
`else
  localparam bit VEC = 1'b0;
`endif

  // Expected word layout: {rw, vrw, mtr, mw, md, ms, as, sc, rd, alu[2:0]}
  localparam int W = 12;

  logic        clk;
  logic        reset;
  logic [5:0]  opD, functD;
  logic [31:0] srca2D, srcb2D;
  logic        flushE;
  logic        jumpD, pcsrcD;
  logic [1:0]  branchD;
  logic        alusrcE, scalarE, regdstE;
  logic [2:0]  alucontrolE;
  logic        memwriteM, memdataM, memsrcM;
  logic        regwriteE, regwriteM, regwriteW, VregwriteW;
  logic        memtoregE, memtoregM, memtoregW;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  control_unit dut (
    .clk(clk), .reset(reset), .opD(opD), .functD(functD),
    .srca2D(srca2D), .srcb2D(srcb2D), .flushE(flushE),
    .jumpD(jumpD), .branchD(branchD), .pcsrcD(pcsrcD),
    .alusrcE(alusrcE), .scalarE(scalarE), .alucontrolE(alucontrolE),
    .regdstE(regdstE), .memwriteM(memwriteM), .memdataM(memdataM),
    .memsrcM(memsrcM), .regwriteE(regwriteE), .regwriteM(regwriteM),
    .regwriteW(regwriteW), .VregwriteW(VregwriteW), .memtoregE(memtoregE),
    .memtoregM(memtoregM), .memtoregW(memtoregW)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model_ctrl(input logic [5:0] op,
                                              input logic [5:0] fn);
    int   opn;
    bit   rw, vrw, mtr, mw, md, ms, as, sc, rd;
    bit   vdest, store, wide;
    logic [2:0] alu;
    opn = int'(op);
    {rw, vrw, mtr, mw, md, ms, as, sc, rd} = '0;
    alu = 3'd0;
    vdest = 1'b0; store = 1'b0; wide = 1'b0;
    if (opn == 0) begin
      rw = 1; rd = 1; alu = fn[2:0];
    end else if (VEC && (opn == 4 || opn == 12)) begin
      vrw = 1; rd = 1; alu = fn[2:0]; sc = (opn == 12);
    end else if (opn >= 16 && opn < 32) begin
      vdest = ((opn / 4) % 2) == 1;
      if (!vdest || VEC) begin
        as = 1; alu = 3'(opn % 4); rw = !vdest; vrw = vdest;
        sc = ((opn / 8) % 2) == 1;
      end
    end else if (opn >= 32 && opn <= 35) begin
      store = (opn % 2) == 1;
      wide  = ((opn / 2) % 2) == 1;
      if (!wide || VEC) begin
        as = 1; ms = wide;
        if (store) begin
          mw = 1; md = wide;
        end else begin
          mtr = 1;
          if (wide) vrw = 1; else rw = 1;
        end
      end
    end
    return {rw, vrw, mtr, mw, md, ms, as, sc, rd, alu};
  endfunction

  function automatic logic [1:0] model_branch(input logic [5:0] op);
    if (op == 6'd50) return 2'd1;
    if (op == 6'd49) return 2'd2;
    return 2'd0;
  endfunction

  // ---------------- output checks ----------------
  task automatic check_d(input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    logic [1:0] br;
    br = model_branch(op);
    check_eq("jumpD",   32'(jumpD),   32'(op == 6'd63));
    check_eq("branchD", 32'(branchD), 32'(br));
    check_eq("pcsrcD",  32'(pcsrcD),
             32'((br == 2'd1 && a == b) || (br == 2'd2 && a != b)));
  endtask

  task automatic check_pipe();
    logic [W-1:0] e, m, w;
    e = exp_q[0]; m = exp_q[1]; w = exp_q[2];
    check_eq("stage_E",
      32'({regwriteE, memtoregE, alusrcE, scalarE, regdstE, alucontrolE}),
      32'({e[11], e[9], e[5], e[4] & VEC, e[3], e[2:0]}));
    check_eq("stage_M",
      32'({regwriteM, memtoregM, memwriteM, memdataM, memsrcM}),
      32'({m[11], m[9], m[8], m[7], m[6]}));
    check_eq("stage_W",
      32'({regwriteW, VregwriteW, memtoregW}),
      32'({w[11], w[10], w[9]}));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, 32'({alusrcE, scalarE, alucontrolE, regdstE, memwriteM,
                       memdataM, memsrcM, regwriteE, regwriteM, regwriteW,
                       VregwriteW, memtoregE, memtoregM, memtoregW}), 32'd0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic [5:0] op, input logic [5:0] fn,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic fl);
    @(negedge clk);
    opD = op; functD = fn; srca2D = a; srcb2D = b; flushE = fl;
    #1 check_d(op, a, b);
    @(posedge clk);
    #1;
    exp_q.push_front(fl ? '0 : model_ctrl(op, fn));
    while (exp_q.size() > 3) void'(exp_q.pop_back());
    check_pipe();
  endtask

  task automatic nop();
    step(6'b101010, 6'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_all_zero("async_reset_now");
    check_d(opD, srca2D, srcb2D);
    @(posedge clk);
    #1 check_all_zero("async_reset_hold");
    reset = 1'b0;
    exp_q = '{'0, '0, '0};
  endtask

  logic [5:0] pool [14];

  // ---------------- main sequence ----------------
  initial begin
    pool = '{6'b000000, 6'b000100, 6'b001100, 6'b010000, 6'b010110,
             6'b011011, 6'b011101, 6'b100000, 6'b100001, 6'b100010,
             6'b100011, 6'b110010, 6'b110001, 6'b111111};
    reset = 1'b1; opD = 6'd0; functD = 6'd0; srca2D = '0; srcb2D = '0;
    flushE = 1'b0;
    exp_q = '{'0, '0, '0};

    // Reset state, and Decode outputs still live during reset.
    @(posedge clk); @(posedge clk);
    #1 check_all_zero("reset_state");
    opD = 6'b111111;
    #1 check_eq("jumpD_in_reset", 32'(jumpD), 32'd1);
    opD = 6'd0;
    @(posedge clk);
    #1 reset = 1'b0;

    // First instruction after release.
    step(6'b000000, 6'b000001, 32'd0, 32'd0, 1'b0);
    check_eq("rtype_regwriteE", 32'(regwriteE), 32'd1);
    check_eq("rtype_regdstE",   32'(regdstE),   32'd1);
    check_eq("rtype_aluE",      32'(alucontrolE), 32'd1);
    nop(); nop();
    check_eq("rtype_regwriteW", 32'(regwriteW), 32'd1);

    // Vector-scalar R-type.
    step(6'b001100, 6'b100110, 32'd0, 32'd0, 1'b0);
    check_eq("vs_scalarE",   32'(scalarE),     32'(VEC));
    check_eq("vs_aluE",      32'(alucontrolE), VEC ? 32'd6 : 32'd0);
    check_eq("vs_regwriteE", 32'(regwriteE),   32'd0);
    nop(); nop();
    check_eq("vs_vregW",     32'(VregwriteW),  32'(VEC));

    // Vector immediate.
    step(6'b010110, 6'd0, 32'd0, 32'd0, 1'b0);
    check_eq("vi_alusrcE", 32'(alusrcE),     32'(VEC));
    check_eq("vi_aluE",    32'(alucontrolE), VEC ? 32'd2 : 32'd0);
    nop(); nop();
    check_eq("vi_vregW",   32'(VregwriteW),  32'(VEC));

    // Loads and stores.
    step(6'b100000, 6'd0, 32'd0, 32'd0, 1'b0);
    nop(); nop();
    check_eq("lw_memtoregW", 32'(memtoregW), 32'd1);
    check_eq("lw_regwriteW", 32'(regwriteW), 32'd1);
    step(6'b100011, 6'd0, 32'd0, 32'd0, 1'b0);
    nop();
    check_eq("vsw_M", 32'({memwriteM, memdataM, memsrcM}), VEC ? 32'd7 : 32'd0);
    nop();
    check_eq("vsw_W", 32'({regwriteW, VregwriteW, memtoregW}), 32'd0);

    // Branches.
    step(6'b110010, 6'd0, 32'd5, 32'd5, 1'b0);
    check_eq("beq_branchD", 32'(branchD), 32'd1);
    check_eq("beq_taken",   32'(pcsrcD),  32'd1);
    step(6'b110010, 6'd0, 32'd5, 32'd6, 1'b0);
    check_eq("beq_not_taken", 32'(pcsrcD), 32'd0);
    step(6'b110001, 6'd0, 32'd5, 32'd6, 1'b0);
    check_eq("bne_branchD", 32'(branchD), 32'd2);
    check_eq("bne_taken",   32'(pcsrcD),  32'd1);
    step(6'b110010, 6'd0, 32'h8000_0005, 32'h0000_0005, 1'b0);
    check_eq("beq_msb_diff", 32'(pcsrcD), 32'd0);

    // Jump and illegal opcode.
    step(6'b111111, 6'b100101, 32'd0, 32'd0, 1'b0);
    check_eq("jump_jumpD",   32'(jumpD),     32'd1);
    check_eq("jump_writesE", 32'({regwriteE, memtoregE}), 32'd0);
    step(6'b101010, 6'b111111, 32'd0, 32'd0, 1'b0);
    check_all_zero("illegal_after_jump_pipeline");

    // Flush bubble travels to W.
    step(6'b000000, 6'd0, 32'd0, 32'd0, 1'b1);
    check_eq("flush_regwriteE", 32'(regwriteE), 32'd0);
    step(6'b000000, 6'd0, 32'd0, 32'd0, 1'b0);
    step(6'b000000, 6'd0, 32'd0, 32'd0, 1'b0);
    check_eq("flush_bubble_W", 32'(regwriteW), 32'd0);
    step(6'b000000, 6'd0, 32'd0, 32'd0, 1'b0);
    check_eq("flush_after_W", 32'(regwriteW), 32'd1);

    // Randomized traffic with one asynchronous reset in the middle.
    for (int i = 0; i < 300; i++) begin
      logic [5:0]  op, fn;
      logic [31:0] a, b;
      logic        fl;
      if (i == 150) async_reset();
      op = ($urandom_range(0, 3) == 0) ? 6'($urandom)
                                       : pool[$urandom_range(0, 13)];
      fn = 6'($urandom);
      a  = $urandom;
      b  = ($urandom_range(0, 1) == 0) ? a : $urandom;
      fl = ($urandom_range(0, 7) == 0);
      step(op, fn, a, b, fl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
